// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
//   op_e    : OP field encodings (MULT, MULTU, DIV, DIVU)
//   state_e : sequencer states (IDLE, RUN, FIX)
//   DIV0_QUO_BIT : fill bit of the quotient written on divide by zero
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   // Divide by zero leaves an all-ones quotient (replicated to WIDTH).
   localparam logic DIV0_QUO_BIT = 1'b1;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational sign correction of the unsigned core result.
//   is_div   : 1 = divide result (hi=remainder, lo=quotient), 0 = product
//   neg_prod : negate the full 2*WIDTH product
//   neg_quo  : negate the quotient
//   neg_rem  : negate the remainder
//   mag_hi/mag_lo : unsigned core result
//   res_hi/res_lo : corrected HI/LO values
module mdu_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic             neg_prod,
   input  logic             neg_quo,
   input  logic             neg_rem,
   input  logic [WIDTH-1:0] mag_hi,
   input  logic [WIDTH-1:0] mag_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;

   always_comb begin
      prod     = {mag_hi, mag_lo};
      prod_fix = neg_prod ? (~prod + (2*WIDTH)'(1)) : prod;
      if (is_div) begin
         res_hi = neg_rem ? (~mag_hi + WIDTH'(1)) : mag_hi;
         res_lo = neg_quo ? (~mag_lo + WIDTH'(1)) : mag_lo;
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning HI and LO.
//   CLK, RST (sync, active high)
//   START, OP, SRC_A, SRC_B : launch MULT/MULTU/DIV/DIVU
//   HI_WE, LO_WE, WR_DATA   : MTHI / MTLO writes, honoured only when idle
//   BUSY  : operation in progress (IDLE excluded)
//   DONE  : one-cycle pulse once new HI/LO are visible
//   HI, LO: architectural registers
// One shift-add / restoring shift-subtract step per cycle over WIDTH cycles,
// then one FIX cycle for sign correction and the HI/LO write.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [1:0]       OP,
   input  logic [WIDTH-1:0] SRC_A,
   input  logic [WIDTH-1:0] SRC_B,
   input  logic             HI_WE,
   input  logic             LO_WE,
   input  logic [WIDTH-1:0] WR_DATA,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_e state, state_n;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_hi;    // product high half / partial remainder
   logic [WIDTH-1:0] acc_lo;    // multiplier -> product low / dividend -> quotient
   logic [WIDTH-1:0] opnd;      // multiplicand magnitude / divisor magnitude
   logic             is_div;
   logic             neg_prod;
   logic             neg_quo;
   logic             neg_rem;
   logic             div_zero;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             done_q;

   // operand capture
   logic             op_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   // iteration step
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ok;

   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;

   always_comb begin
      op_signed = (OP == OP_MULT) || (OP == OP_DIV);
      a_neg     = op_signed & SRC_A[WIDTH-1];
      b_neg     = op_signed & SRC_B[WIDTH-1];
      a_mag     = a_neg ? (~SRC_A + WIDTH'(1)) : SRC_A;
      b_mag     = b_neg ? (~SRC_B + WIDTH'(1)) : SRC_B;
   end

   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      // The shifted remainder is below 2*divisor, so bit WIDTH of the
      // difference is set exactly when the subtraction would go negative.
      div_ok    = ~div_diff[WIDTH];
   end

   mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .is_div   (is_div),
      .neg_prod (neg_prod),
      .neg_quo  (neg_quo),
      .neg_rem  (neg_rem),
      .mag_hi   (acc_hi),
      .mag_lo   (acc_lo),
      .res_hi   (fix_hi),
      .res_lo   (fix_lo)
   );

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (START) state_n = RUN;
         RUN:     if (cnt == LAST_STEP) state_n = FIX;
         FIX:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
         neg_prod <= 1'b0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  cnt      <= '0;
                  acc_hi   <= '0;
                  is_div   <= OP[1];
                  opnd     <= OP[1] ? b_mag : a_mag;
                  acc_lo   <= OP[1] ? a_mag : b_mag;
                  neg_prod <= a_neg ^ b_neg;
                  neg_quo  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  div_zero <= OP[1] && (SRC_B == '0);
               end else begin
                  if (HI_WE) hi_q <= WR_DATA;
                  if (LO_WE) lo_q <= WR_DATA;
               end
            end
            RUN: begin
               cnt <= cnt + CNT_W'(1);
               if (is_div) begin
                  acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
               end else begin
                  acc_hi <= mul_sum[WIDTH:1];
                  acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               end
            end
            FIX: begin
               // Remainder already equals the dividend on divide by zero;
               // only the quotient needs forcing (its sign flag is meaningless).
               hi_q   <= fix_hi;
               lo_q   <= div_zero ? {WIDTH{DIV0_QUO_BIT}} : fix_lo;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign BUSY = (state != IDLE);
   assign DONE = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed results; a monitor
// pops the expected HI/LO from a scoreboard queue on every DONE pulse.
module tb_mult_div_unit;

   localparam int W = 32;
   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          START = 1'b0;
   logic [1:0]    OP = 2'b00;
   logic [W-1:0]  SRC_A = '0, SRC_B = '0;
   logic          HI_WE = 1'b0, LO_WE = 1'b0;
   logic [W-1:0]  WR_DATA = '0;
   logic          BUSY, DONE;
   logic [W-1:0]  HI, LO;

   int n_vec = 0;
   int n_err = 0;
   int done_seen = 0;
   logic [2*W-1:0] sb[$];

   mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .CLK(CLK), .RST(RST), .START(START), .OP(OP),
      .SRC_A(SRC_A), .SRC_B(SRC_B),
      .HI_WE(HI_WE), .LO_WE(LO_WE), .WR_DATA(WR_DATA),
      .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge CLK) begin
      if (!RST && DONE) begin
         done_seen++;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got DONE=1 want no pending op");
         end else begin
            logic [2*W-1:0] e;
            e = sb.pop_front();
            chk("result_hi", HI, e[2*W-1:W]);
            chk("result_lo", LO, e[W-1:0]);
         end
      end
   end

   // Drive START for one cycle; operands are scrambled afterwards since
   // they are don't-care once captured.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic push, input logic [2*W-1:0] exp, input logic lo_we);
      @(posedge CLK); #1;
      START = 1'b1; OP = op; SRC_A = a; SRC_B = b;
      LO_WE = lo_we; WR_DATA = 32'hCAFEF00D;
      if (push) sb.push_back(exp);
      @(posedge CLK); #1;
      START = 1'b0; LO_WE = 1'b0;
      SRC_A = $urandom; SRC_B = $urandom; OP = 2'($urandom);
   endtask

   // Counts BUSY cycles, optionally pokes HI_WE / a second START while busy,
   // then checks the DONE pulse shape.
   task automatic wait_done(input int we_cycles, input int start_at, input logic [W-1:0] hi_hold);
      int busy_cnt;
      busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!BUSY) break;
         busy_cnt++;
         if (we_cycles > 0 && busy_cnt > 1) chk("hi_hold_busy", HI, hi_hold);
         HI_WE   = (busy_cnt <= we_cycles);
         WR_DATA = 32'hDEADBEEF;
         START   = (busy_cnt == start_at);
      end
      HI_WE = 1'b0;
      START = 1'b0;
      chk("busy_cycles", busy_cnt, W + 1);
      chk("done_pulse", DONE, 1);
      @(negedge CLK);
      chk("done_len", DONE, 0);
   endtask

   task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ehi, input logic [W-1:0] elo);
      issue(op, a, b, 1'b1, {ehi, elo}, 1'b0);
      wait_done(0, 0, '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_hi", HI, 0);
      chk("rst_lo", LO, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);

      run(MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run(MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA);
      run(DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run(DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run(DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
      run(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

      // MTHI alone, then both together, then MTHI again
      @(posedge CLK); #1;
      HI_WE = 1'b1; WR_DATA = 32'h12345678;
      @(posedge CLK); #1;
      HI_WE = 1'b0;
      chk("mthi_hi", HI, 32'h12345678);
      chk("mthi_lo_keep", LO, 32'h80000000);
      HI_WE = 1'b1; LO_WE = 1'b1; WR_DATA = 32'hA5A5A5A5;
      @(posedge CLK); #1;
      HI_WE = 1'b0; LO_WE = 1'b0;
      chk("both_hi", HI, 32'hA5A5A5A5);
      chk("both_lo", LO, 32'hA5A5A5A5);
      HI_WE = 1'b1; WR_DATA = 32'h12345678;
      @(posedge CLK); #1;
      HI_WE = 1'b0;

      // HI_WE held during busy and a second START mid-operation: both ignored
      issue(MULTU, 32'd5, 32'd7, 1'b1, {32'h0, 32'h23}, 1'b0);
      wait_done(10, 5, 32'h12345678);

      // START together with LO_WE: write dropped
      issue(DIVU, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, 1'b1);
      chk("start_lowe_drop", LO, 32'h23);
      wait_done(0, 0, '0);

      // reset mid-operation aborts without a later DONE
      issue(MULT, 32'd5, 32'd7, 1'b0, '0, 1'b0);
      repeat (9) @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("abort_hi", HI, 0);
      chk("abort_lo", LO, 0);
      chk("abort_busy", BUSY, 0);
      chk("abort_done", DONE, 0);
      begin
         int seen0;
         seen0 = done_seen;
         repeat (40) @(negedge CLK);
         chk("abort_no_done", done_seen, seen0);
      end

      run(MULTU, 32'd5, 32'd7, 32'h0, 32'h23);

      repeat (3) @(negedge CLK);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit owning the HI and LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO and MFHI/MFLO.
- Sits in the execute stage beside the ALU.
- HI and LO feed the 2:1 result-select muxes ahead of register-file writeback.
- Control stalls the PC while BUSY is high.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >= 4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous active-high reset
START  input  1  launch operation OP on SRC_A/SRC_B
OP  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
SRC_A  input  WIDTH  multiplicand / dividend (rs)
SRC_B  input  WIDTH  multiplier / divisor (rt)
HI_WE  input  1  MTHI: load WR_DATA into HI
LO_WE  input  1  MTLO: load WR_DATA into LO
WR_DATA  input  WIDTH  data for MTHI/MTLO
BUSY  output  1  operation in progress
DONE  output  1  one-cycle pulse when the new HI/LO are valid
HI  output  WIDTH  HI register (product high / remainder)
LO  output  WIDTH  LO register (product low / quotient)

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Reset: state IDLE; HI=0, LO=0, BUSY=0, DONE=0; counter and working registers cleared.
- RST mid-operation aborts the operation. Nothing is written to HI/LO except the reset zeros.
- States:
  - IDLE: BUSY=0. START=1 captures operands and goes to RUN with count=0.
  - RUN: BUSY=1. One shift-add (multiply) or one restoring shift-subtract (divide) step per cycle. After WIDTH steps, go to FIX.
  - FIX: BUSY=1. Apply sign correction, write HI/LO, go to IDLE.
- Latency:
  - START sampled at edge E0.
  - BUSY is high after E0 through E0+WIDTH+1 (WIDTH+1 cycles).
  - HI/LO update at edge E0+WIDTH+1.
  - DONE=1 for exactly the cycle following that edge.
  - A new START may be accepted in that same DONE cycle.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at capture; the core iterates unsigned.
  - Product is negated in FIX when the operand signs differ.
  - Quotient is negated when the signs differ. Remainder takes the dividend's sign.
- Unsigned ops (MULTU, DIVU): no correction. FIX only writes HI/LO.
- MULT/MULTU result: full 2*WIDTH product, HI = upper half, LO = lower half.
- Divide by zero (DIV or DIVU, SRC_B=0): LO = all ones, HI = SRC_A as captured. Iteration still runs; latency is unchanged.
- DIV overflow (most-negative / -1): LO = 0x80000000, HI = 0. This is the natural truncated result; no special flag.
- HI_WE/LO_WE:
  - Honoured only in IDLE; take effect at the next edge.
  - Both may be asserted together.
  - Ignored while BUSY.
- START in IDLE together with HI_WE/LO_WE: START wins and the write is dropped.
- START while BUSY is ignored; the current operation continues unchanged.
- Operand stability: SRC_A, SRC_B and OP are needed only in the START cycle. They are don't-care afterwards.
- HI/LO hold their values while BUSY. They change only on completion, MTHI/MTLO, or reset.
- OP values are all legal (2-bit field); no default trap required.

Decomposition:
- Shared package mdu_pkg holds:
  - OP encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encoding: IDLE, RUN, FIX.
  - Divide-by-zero quotient constant.
- One natural sub-module: mdu_sign_fix. It is combinational: it takes the magnitudes and sign flags and returns corrected HI/LO. It is shared by the multiply and divide paths.
- Counter and FSM stay in the top module.

Test Plan:
- Reset, then MULT SRC_A=0xFFFFFFFE, SRC_B=0x00000003 -> BUSY high for 33 cycles; DONE one cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU SRC_A=0xFFFFFFFE, SRC_B=0x00000003 -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV SRC_A=0xFFFFFFF9 (-7), SRC_B=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 0x00000007/0 -> LO=0xFFFFFFFF, HI=0x00000007, same latency.
- DIV SRC_A=0x80000000, SRC_B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- MTHI WR_DATA=0x12345678 in IDLE -> HI=0x12345678 next cycle. HI_WE asserted while BUSY -> HI unchanged until completion. START with LO_WE in IDLE -> write dropped. Second START mid-operation -> ignored.
- Start MULT 5*7, assert RST at cycle 10 -> next cycle HI=0, LO=0, BUSY=0, DONE=0, no later DONE pulse. Fresh MULTU 5*7 afterwards -> LO=0x00000023.
